// File: rtl/ustc_sparse_idx_gen.sv
// Builds crossbar select indices that compact the nonzero lanes of a dense line into the low output lanes.
// Two registered stages at full throughput; a stalled output freezes stage 2 and stage 1 keeps one more beat.
module ustc_sparse_idx_gen #(
  parameter int N            = 8,
  parameter int DW_DATA      = 32,
  parameter int DW_IDX       = 4,
  parameter int NUM_PER_LINE = 1,
  parameter int DW_LINE      = DW_DATA * NUM_PER_LINE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DW_LINE-1:0] in_data,
  input  logic [N-1:0]         in_mask,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*DW_LINE-1:0] out_data,
  output logic [N*DW_IDX-1:0]  out_idx,
  output logic [DW_IDX-1:0]    out_cnt,
  output logic                 out_last,
  output logic [15:0]          out_frame_nz
);

  logic                 s1_valid;
  logic [N*DW_LINE-1:0] s1_data;
  logic [N-1:0]         s1_mask;
  logic                 s1_last;
  logic [N*DW_IDX-1:0]  s1_pos;
  logic                 s1_adv;
  logic [15:0]          acc;

  logic [N*DW_IDX-1:0]  pos_nxt;
  logic [DW_IDX-1:0]    run;
  logic [N*DW_IDX-1:0]  idx_nxt;
  logic [DW_IDX-1:0]    cnt_nxt;
  logic [15:0]          acc_eff;
  logic [16:0]          sum;
  logic [15:0]          frame_nxt;

  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = reset && (!s1_valid || s1_adv);

  // Exclusive prefix popcount: destination slot of each kept lane.
  always_comb begin
    pos_nxt = '0;
    run     = '0;
    for (int i = 0; i < N; i++) begin
      pos_nxt[i*DW_IDX +: DW_IDX] = run;
      run = run + DW_IDX'(in_mask[i]);
    end
  end

  always_comb begin
    idx_nxt = '0;
    for (int j = 0; j < N; j++) begin
      idx_nxt[j*DW_IDX +: DW_IDX] = DW_IDX'(N);
      for (int i = 0; i < N; i++) begin
        if (s1_mask[i] && s1_pos[i*DW_IDX +: DW_IDX] == DW_IDX'(j))
          idx_nxt[j*DW_IDX +: DW_IDX] = DW_IDX'(i);
      end
    end
  end

  assign cnt_nxt = s1_pos[(N-1)*DW_IDX +: DW_IDX] + DW_IDX'(s1_mask[N-1]);

  // A beat entering stage 2 in the same cycle the previous one leaves must see the post-transfer total.
  assign acc_eff   = (out_valid && out_ready) ? (out_last ? 16'd0 : out_frame_nz) : acc;
  assign sum       = {1'b0, acc_eff} + 17'(cnt_nxt);
  assign frame_nxt = sum[16] ? 16'hFFFF : sum[15:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mask  <= '0;
      s1_last  <= 1'b0;
      s1_pos   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mask <= in_mask;
        s1_last <= in_last;
        s1_pos  <= pos_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_idx      <= '0;
      out_cnt      <= '0;
      out_last     <= 1'b0;
      out_frame_nz <= '0;
      acc          <= '0;
    end else begin
      if (s1_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data     <= s1_data;
          out_idx      <= idx_nxt;
          out_cnt      <= cnt_nxt;
          out_last     <= s1_last;
          out_frame_nz <= frame_nxt;
        end
      end
      if (out_valid && out_ready)
        acc <= out_last ? 16'd0 : out_frame_nz;
    end
  end

endmodule
